// File: rtl/mem_wait_responder.sv
// Wait-state word memory responder: accepts one request at a time and returns a
// one-cycle Ready pulse with read data or a fault flag after LATENCY wait cycles.
module mem_wait_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        Fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d, wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        ready_q, busy_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, commit, c_we, c_fault, mem_we;
    logic [31:0]   c_adr, c_wdata;
    logic [AW-1:0] c_idx;

    // A commit normally uses the latched request; with zero latency the request
    // commits on the same edge it is accepted, so the live inputs are used.
    always_comb begin
        accept  = Req && (state_q != WAIT);
        commit  = ((state_q == WAIT) && (cnt_q == 4'd0)) || (accept && (LATENCY == 0));
        c_adr   = (state_q == WAIT) ? adr_q   : Adr;
        c_wdata = (state_q == WAIT) ? wdata_q : WriteData;
        c_we    = (state_q == WAIT) ? we_q    : MemWrite;
        c_fault = (c_adr[1:0] != 2'b00) || (c_adr[31:AW+2] != '0);
        c_idx   = c_adr[AW+1:2];
        mem_we  = commit && c_we && !c_fault && !reset;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    adr_d   = Adr;
                    wdata_d = WriteData;
                    we_d    = MemWrite;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 0) ? DONE : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            fault_d = c_fault;
            rdata_d = (c_fault || c_we) ? 32'd0 : mem[c_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            ready_q <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[c_idx] <= c_wdata;
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign Fault    = fault_q;
endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a LATENCY=2 and a LATENCY=0 instance
// driven from vector tables plus hand-written multi-cycle sequences.
module tb_mem_wait_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req2, we2, rdy2, bsy2, flt2;
    logic [31:0] adr2, wd2, rd2;
    logic        req0, we0, rdy0, bsy0, flt0;
    logic [31:0] adr0, wd0, rd0;

    int total = 0;
    int bad   = 0;

    mem_wait_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .Req(req2), .MemWrite(we2), .Adr(adr2),
        .WriteData(wd2), .ReadData(rd2), .Ready(rdy2), .Busy(bsy2), .Fault(flt2));

    mem_wait_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .Req(req0), .MemWrite(we0), .Adr(adr0),
        .WriteData(wd0), .ReadData(rd0), .Ready(rdy0), .Busy(bsy0), .Fault(flt0));

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        flt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Single LATENCY=2 transaction; starts and ends on a falling edge.
    task automatic run2(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        req2 = 1'b1; we2 = v.we; adr2 = v.adr; wd2 = v.wd;
        @(negedge clk);
        req2 = 1'b0; we2 = ~v.we; adr2 = ~v.adr; wd2 = ~v.wd;
        chk({tag, " w1 ready"}, 32'(rdy2), 32'd0);
        chk({tag, " w1 busy"},  32'(bsy2), 32'd1);
        @(negedge clk);
        chk({tag, " w2 ready"}, 32'(rdy2), 32'd0);
        @(negedge clk);
        chk({tag, " ready"}, 32'(rdy2), 32'd1);
        chk({tag, " busy"},  32'(bsy2), 32'd1);
        chk({tag, " fault"}, 32'(flt2), 32'(v.flt));
        chk({tag, " rdata"}, rd2, v.rd);
        @(negedge clk);
        chk({tag, " idle ready"}, 32'(rdy2), 32'd0);
        chk({tag, " idle busy"},  32'(bsy2), 32'd0);
    endtask

    vec_t tv2 [9];
    vec_t tv0 [7];

    initial begin
        tv2[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tv2[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv2[2] = '{1'b0, 32'h102, 32'h0,        32'h0,        1'b1};
        tv2[3] = '{1'b1, 32'h0,   32'h0,        32'h0,        1'b0};
        tv2[4] = '{1'b1, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1};
        tv2[5] = '{1'b0, 32'h0,   32'h0,        32'h0,        1'b0};
        tv2[6] = '{1'b1, 32'h30,  32'h11111111, 32'h0,        1'b0};
        tv2[7] = '{1'b1, 32'hFC,  32'hCAFEF00D, 32'h0,        1'b0};
        tv2[8] = '{1'b0, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0};

        tv0[0] = '{1'b1, 32'h0, 32'hA0A0A0A0, 32'h0,        1'b0};
        tv0[1] = '{1'b1, 32'h4, 32'hB1B1B1B1, 32'h0,        1'b0};
        tv0[2] = '{1'b1, 32'h8, 32'hC2C2C2C2, 32'h0,        1'b0};
        tv0[3] = '{1'b0, 32'h0, 32'h0,        32'hA0A0A0A0, 1'b0};
        tv0[4] = '{1'b0, 32'h4, 32'h0,        32'hB1B1B1B1, 1'b0};
        tv0[5] = '{1'b0, 32'h3, 32'h0,        32'h0,        1'b1};
        tv0[6] = '{1'b0, 32'h8, 32'h0,        32'hC2C2C2C2, 1'b0};

        reset = 1'b1;
        req2 = 1'b1; we2 = 1'b1; adr2 = 32'h10; wd2 = 32'h1;
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'h10; wd0 = 32'h1;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(rdy2), 32'd0);
        chk("rst busy",  32'(bsy2), 32'd0);
        chk("rst fault", 32'(flt2), 32'd0);
        chk("rst rdata", rd2, 32'd0);
        chk("rst busy l0", 32'(bsy0), 32'd0);
        reset = 1'b0; req2 = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("post rst busy", 32'(bsy2), 32'd0);

        for (int i = 0; i < 9; i++) run2(tv2[i], i);

        // Back-to-back: write then read accepted in the write's DONE cycle.
        req2 = 1'b1; we2 = 1'b1; adr2 = 32'h20; wd2 = 32'h12345678;
        @(negedge clk);
        we2 = 1'b0; wd2 = 32'h0;
        chk("b2b w1 ready", 32'(rdy2), 32'd0);
        @(negedge clk);
        chk("b2b w2 ready", 32'(rdy2), 32'd0);
        @(negedge clk);
        chk("b2b wr ready", 32'(rdy2), 32'd1);
        chk("b2b wr fault", 32'(flt2), 32'd0);
        @(negedge clk);
        chk("b2b r1 ready", 32'(rdy2), 32'd0);
        chk("b2b r1 busy",  32'(bsy2), 32'd1);
        @(negedge clk);
        chk("b2b r2 ready", 32'(rdy2), 32'd0);
        @(negedge clk);
        req2 = 1'b0;
        chk("b2b rd ready", 32'(rdy2), 32'd1);
        chk("b2b rd data",  rd2, 32'h12345678);
        @(negedge clk);
        chk("b2b end busy", 32'(bsy2), 32'd0);

        // Req pulse while in WAIT must be ignored.
        req2 = 1'b1; we2 = 1'b0; adr2 = 32'h10;
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; adr2 = 32'h10; wd2 = 32'h55555555;
        @(negedge clk);
        req2 = 1'b0;
        @(negedge clk);
        chk("wreq ready", 32'(rdy2), 32'd1);
        chk("wreq data",  rd2, 32'hDEADBEEF);
        @(negedge clk);
        chk("wreq no extra ready", 32'(rdy2), 32'd0);
        chk("wreq no extra busy",  32'(bsy2), 32'd0);
        run2('{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0}, 90);

        // Reset in the last WAIT cycle aborts the write.
        req2 = 1'b1; we2 = 1'b1; adr2 = 32'h30; wd2 = 32'hAAAA5555;
        @(negedge clk);
        req2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort ready", 32'(rdy2), 32'd0);
        chk("abort busy",  32'(bsy2), 32'd0);
        @(negedge clk);
        chk("abort later ready", 32'(rdy2), 32'd0);
        run2('{1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0}, 91);

        // LATENCY=0: Req held high, one completion every cycle.
        for (int i = 0; i < 7; i++) begin
            req0 = 1'b1; we0 = tv0[i].we; adr0 = tv0[i].adr; wd0 = tv0[i].wd;
            @(negedge clk);
            chk($sformatf("l0 v%0d ready", i), 32'(rdy0), 32'd1);
            chk($sformatf("l0 v%0d fault", i), 32'(flt0), 32'(tv0[i].flt));
            chk($sformatf("l0 v%0d rdata", i), rd0, tv0[i].rd);
        end
        req0 = 1'b0;
        @(negedge clk);
        chk("l0 end ready", 32'(rdy0), 32'd0);
        chk("l0 end busy",  32'(bsy0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
